// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC sequencing, instruction memory requests and a
// DEPTH-entry prefetch buffer feeding the decode stage, with branch redirect.
// Optional feature macro IFU_PERF_CNT_EN adds saturating stall_cnt/flush_cnt.
module instruction_fetch_unit #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [23:0]       imem_rdata,
  output logic [23:0]       ins,
  output logic              ins_valid,
  input  logic              stall,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  output logic [ADDR_W-1:0] fetch_pc
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       flush_cnt
`endif
);

  localparam int unsigned INS_W = 24;
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  // Occupancy = buffered + response arriving now + request issued now.
  localparam int unsigned OCC_W = $clog2(DEPTH + 3);

  typedef enum logic [1:0] {FETCH, WAIT_FULL, FLUSH} state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [INS_W-1:0]  data;
  } entry_t;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  entry_t            mem_q [DEPTH];
  entry_t            mem_d [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [INS_W-1:0]  ins_q, ins_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] fpc_q, fpc_d;

  logic              pop_c;
  logic              push_c;
  logic              issue_c;
  logic [OCC_W-1:0]  occ_c;

  // Next-state, request issue and buffer update; a branch overrides everything.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_d       = 1'b0;
    addr_d      = addr_q;
    pend_d      = req_q;
    pend_addr_d = addr_q;
    mem_d       = mem_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    ins_d       = '0;
    valid_d     = 1'b0;
    fpc_d       = '0;
    issue_c     = 1'b0;

    pop_c  = valid_q && !stall;
    push_c = pend_q;
    occ_c  = OCC_W'(count_q) + OCC_W'(pend_q) + OCC_W'(req_q) - OCC_W'(pop_c);

    if (br_taken) begin
      state_d  = FLUSH;
      pc_d     = br_target;
      pend_d   = 1'b0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      case (state_q)
        FLUSH:   issue_c = 1'b1;
        default: issue_c = (occ_c < OCC_W'(DEPTH));
      endcase

      if (issue_c) begin
        state_d = FETCH;
        req_d   = 1'b1;
        addr_d  = pc_q;
        pc_d    = pc_q + ADDR_W'(1);
      end else begin
        state_d = WAIT_FULL;
      end

      if (push_c) begin
        mem_d[wr_ptr_q] = '{addr: pend_addr_q, data: imem_rdata};
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);

      if (count_d != '0) begin
        valid_d = 1'b1;
        ins_d   = mem_d[rd_ptr_d].data;
        fpc_d   = mem_d[rd_ptr_d].addr;
      end
    end
  end

  // State and datapath registers; reset discards buffer and in-flight response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= FETCH;
      pc_q        <= '0;
      req_q       <= 1'b0;
      addr_q      <= '0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      mem_q       <= '{default: '0};
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      ins_q       <= '0;
      valid_q     <= 1'b0;
      fpc_q       <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_q       <= req_d;
      addr_q      <= addr_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      mem_q       <= mem_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      ins_q       <= ins_d;
      valid_q     <= valid_d;
      fpc_q       <= fpc_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign ins       = ins_q;
  assign ins_valid = valid_q;
  assign fetch_pc  = fpc_q;

`ifdef IFU_PERF_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  // Saturating counters for decode back-pressure and branch redirects.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (valid_q && stall && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
    if (br_taken && (flush_cnt_q != 16'hFFFF))         flush_cnt_d = flush_cnt_q + 16'd1;
  end

  // Counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule
